// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// FSM states, instruction classes and datapath select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXEC,
        S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_MULDIV, S_MFHILO, S_ILLEGAL
    } state_t;

    typedef enum logic [2:0] {
        CL_MEM, CL_RTYPE, CL_MULDIV, CL_MFHILO, CL_ITYPE, CL_BRANCH, CL_JUMP, CL_ILLEGAL
    } instr_class_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] WB_ALUOUT    = 2'b00;
    localparam logic [1:0] WB_MDR       = 2'b01;
    localparam logic [1:0] WB_HI        = 2'b10;
    localparam logic [1:0] WB_LO        = 2'b11;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct classifier; picks the post-DECODE path and the
// per-instruction variants (lw vs sw, bne vs beq, mfhi vs mflo).
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_t class_o,
    output logic         is_lw_o,
    output logic         is_bne_o,
    output logic         is_mfhi_o
);

    always_comb begin
        class_o   = CL_ILLEGAL;
        is_lw_o   = (opcode_i == OP_LW);
        is_bne_o  = (opcode_i == OP_BNE);
        is_mfhi_o = (funct_i == FN_MFHI);
        case (opcode_i)
            OP_LW, OP_SW:                      class_o = CL_MEM;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: class_o = CL_ITYPE;
            OP_BEQ, OP_BNE:                    class_o = CL_BRANCH;
            OP_J:                              class_o = CL_JUMP;
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: class_o = CL_RTYPE;
                    FN_MULT, FN_DIV:                               class_o = CL_MULDIV;
                    FN_MFHI, FN_MFLO:                              class_o = CL_MFHILO;
                    default:                                       class_o = CL_ILLEGAL;
                endcase
            end
            default:                           class_o = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: Moore decode of state (IRWrite/PCWrite follow
// mem_ready in FETCH), mult/div hold counter and retired-instruction counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             BranchNE,
    output logic [1:0]       WBSel,
    output logic             MulDivStart,
    output logic             HiLoWrite,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam int              MD_W    = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] instret_q;

    instr_class_t cls;
    logic         is_lw, is_bne, is_mfhi;

    mips_ctrl_decode u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .class_o   (cls),
        .is_lw_o   (is_lw),
        .is_bne_o  (is_bne),
        .is_mfhi_o (is_mfhi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_START;
            md_cnt_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (instr_done) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUB_RT;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        BranchNE    = 1'b0;
        WBSel       = WB_ALUOUT;
        MulDivStart = 1'b0;
        HiLoWrite   = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = ALUB_IMM_SH;
                case (cls)
                    CL_MEM:    state_d = S_MEM_ADDR;
                    CL_RTYPE:  state_d = S_R_EXEC;
                    CL_MULDIV: begin
                        state_d  = S_MULDIV;
                        md_cnt_d = MD_LOAD;
                    end
                    CL_MFHILO: state_d = S_MFHILO;
                    CL_ITYPE:  state_d = S_I_EXEC;
                    CL_BRANCH: state_d = S_BRANCH;
                    CL_JUMP:   state_d = S_JUMP;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_IMM;
                state_d = is_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                WBSel      = WB_MDR;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_IMM;
                ALUOp   = ALUOP_ITYPE;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNE    = is_bne;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MULDIV: begin
                // Counter still holds its load value only in the entry cycle.
                MulDivStart = (md_cnt_q == MD_LOAD);
                if (md_cnt_q == '0) begin
                    HiLoWrite  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    md_cnt_d = md_cnt_q - MD_W'(1);
                end
            end
            S_MFHILO: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                WBSel      = is_mfhi ? WB_HI : WB_LO;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_START;
        endcase
    end

endmodule
